// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, memory port and pipeline freeze.
// The slave modport is the arbiter's view; the master modport is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int WORD_LEN = 32
);
  logic                if_req;
  logic [WORD_LEN-1:0] if_addr;
  logic [WORD_LEN-1:0] if_rdata;
  logic                if_ready;
  logic                mem_rd_en;
  logic                mem_wr_en;
  logic [WORD_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;
  logic                mem_ready;
  logic                ram_en;
  logic                ram_we;
  logic [WORD_LEN-1:0] ram_addr;
  logic [WORD_LEN-1:0] ram_wdata;
  logic [WORD_LEN-1:0] ram_rdata;
  logic                pipe_freeze;

  modport slave (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, pipe_freeze
  );

  modport master (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, pipe_freeze
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data always wins.
module mem_port_arbiter #(
  parameter int WORD_LEN = 32,
  parameter int MEM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_ACC = 3'd1,
    I_ACC = 3'd2,
    D_RSP = 3'd3,
    I_RSP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [WORD_LEN-1:0] addr_r;
  logic [WORD_LEN-1:0] wdata_r;
  logic                we_r;
  logic [WORD_LEN-1:0] if_rdata_r;
  logic [WORD_LEN-1:0] mem_rdata_r;
  logic                d_pend_s;
  logic                data_prio_s;
  logic                grant_d_s;
  logic                grant_i_s;
  logic                acc_s;
  logic                last_cyc_s;

  assign d_pend_s   = bus.mem_rd_en | bus.mem_wr_en;
  assign acc_s      = (state_r == D_ACC) || (state_r == I_ACC);
  assign last_cyc_s = acc_s && (cnt_r == CNT_LAST);

`ifdef MEM_ARB_RR_EN
  logic last_grant_r;

  // Remember which port won the most recent grant (1 = data, 0 = fetch).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if (grant_d_s) begin
      last_grant_r <= 1'b1;
    end else if (grant_i_s) begin
      last_grant_r <= 1'b0;
    end
  end

  assign data_prio_s = ~last_grant_r;
`else
  assign data_prio_s = 1'b1;
`endif

  // Next-state and grant decision; requests only matter while IDLE.
  always_comb begin
    state_nxt_s = state_r;
    grant_d_s   = 1'b0;
    grant_i_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_pend_s && (data_prio_s || !bus.if_req)) begin
          grant_d_s   = 1'b1;
          state_nxt_s = D_ACC;
        end else if (bus.if_req) begin
          grant_i_s   = 1'b1;
          state_nxt_s = I_ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      D_ACC: begin
        if (last_cyc_s) begin
          state_nxt_s = D_RSP;
        end else begin
          state_nxt_s = D_ACC;
        end
      end
      I_ACC: begin
        if (last_cyc_s) begin
          state_nxt_s = I_RSP;
        end else begin
          state_nxt_s = I_ACC;
        end
      end
      D_RSP:   state_nxt_s = IDLE;
      I_RSP:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latency counter, latched request and per-port read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= {WORD_LEN{1'b0}};
      wdata_r     <= {WORD_LEN{1'b0}};
      we_r        <= 1'b0;
      if_rdata_r  <= {WORD_LEN{1'b0}};
      mem_rdata_r <= {WORD_LEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_d_s) begin
        addr_r  <= bus.mem_addr;
        we_r    <= bus.mem_wr_en;
        wdata_r <= bus.mem_wdata;
      end else if (grant_i_s) begin
        addr_r  <= bus.if_addr;
        we_r    <= 1'b0;
        wdata_r <= {WORD_LEN{1'b0}};
      end
      // The counter stops at MEM_LAT-1 so its width never has to hold a wrap.
      if (state_r == IDLE) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (acc_s && !last_cyc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (last_cyc_s && !we_r) begin
        if (state_r == D_ACC) begin
          mem_rdata_r <= bus.ram_rdata;
        end else begin
          if_rdata_r <= bus.ram_rdata;
        end
      end
    end
  end

  assign bus.ram_en      = acc_s;
  assign bus.ram_we      = acc_s & we_r;
  assign bus.ram_addr    = addr_r;
  assign bus.ram_wdata   = wdata_r;
  assign bus.mem_ready   = (state_r == D_RSP);
  assign bus.if_ready    = (state_r == I_RSP);
  assign bus.mem_rdata   = mem_rdata_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.pipe_freeze = (d_pend_s & ~bus.mem_ready) | (bus.if_req & ~bus.if_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance and one MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        use_model;
  logic [31:0] ram_val;
  int          chk_cnt;
  int          pass_cnt;

  mem_port_arbiter_if #(.WORD_LEN(32)) bus ();
  mem_port_arbiter_if #(.WORD_LEN(32)) bus1 ();

  mem_port_arbiter #(.WORD_LEN(32), .MEM_LAT(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.WORD_LEN(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: either a fixed value or a function of the address.
  always_comb begin
    bus.ram_rdata  = use_model ? (bus.ram_addr ^ K) : ram_val;
    bus1.ram_rdata = bus1.ram_addr ^ K;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0;  bus.if_addr = 32'h0;  bus.mem_rd_en = 1'b0;  bus.mem_wr_en = 1'b0;
    bus.mem_addr = 32'h0;  bus.mem_wdata = 32'h0;
    bus1.if_req = 1'b0; bus1.if_addr = 32'h0; bus1.mem_rd_en = 1'b0; bus1.mem_wr_en = 1'b0;
    bus1.mem_addr = 32'h0; bus1.mem_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    #1;
    chk_cnt++;
    if ({bus.ram_en, bus.ram_we, bus.if_ready, bus.mem_ready, bus.pipe_freeze} !== 5'b0)
      $display("FAIL reset_ctrl got %b exp 00000", {bus.ram_en, bus.ram_we, bus.if_ready, bus.mem_ready, bus.pipe_freeze});
    else pass_cnt++;
    chk_cnt++;
    if (bus.ram_addr !== 32'h0) $display("FAIL reset_ram_addr got %h exp 0", bus.ram_addr); else pass_cnt++;
    chk_cnt++;
    if (bus.ram_wdata !== 32'h0) $display("FAIL reset_ram_wdata got %h exp 0", bus.ram_wdata); else pass_cnt++;
    chk_cnt++;
    if (bus.if_rdata !== 32'h0) $display("FAIL reset_if_rdata got %h exp 0", bus.if_rdata); else pass_cnt++;
    chk_cnt++;
    if (bus.mem_rdata !== 32'h0) $display("FAIL reset_mem_rdata got %h exp 0", bus.mem_rdata); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic exp_en, exp_rdy, exp_frz;
    use_model = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rd_en = (c <= 3);
      bus.mem_addr  = 32'h40;
      ram_val       = (c == 2) ? 32'hDEADBEEF : 32'h0;
      #1;
      exp_en  = (c == 1) || (c == 2);
      exp_rdy = (c == 3);
      exp_frz = (c <= 2);
      chk_cnt++;
      if (bus.ram_en !== exp_en) $display("FAIL load_ram_en c%0d got %b exp %b", c, bus.ram_en, exp_en); else pass_cnt++;
      chk_cnt++;
      if (bus.mem_ready !== exp_rdy) $display("FAIL load_ready c%0d got %b exp %b", c, bus.mem_ready, exp_rdy); else pass_cnt++;
      chk_cnt++;
      if (bus.pipe_freeze !== exp_frz) $display("FAIL load_freeze c%0d got %b exp %b", c, bus.pipe_freeze, exp_frz); else pass_cnt++;
      if (exp_en) begin
        chk_cnt++;
        if (bus.ram_addr !== 32'h40 || bus.ram_we !== 1'b0)
          $display("FAIL load_ram_addr c%0d got %h/%b exp 00000040/0", c, bus.ram_addr, bus.ram_we);
        else pass_cnt++;
      end
      if (exp_rdy) begin
        chk_cnt++;
        if (bus.mem_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata got %h exp deadbeef", bus.mem_rdata); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic exp_en, exp_rdy;
    use_model = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.mem_wr_en = (c <= 3);
      bus.mem_addr  = 32'h80;
      bus.mem_wdata = 32'h12345678;
      ram_val       = 32'hBAD0BAD0;
      #1;
      exp_en  = (c == 1) || (c == 2);
      exp_rdy = (c == 3);
      chk_cnt++;
      if (bus.ram_we !== exp_en) $display("FAIL store_ram_we c%0d got %b exp %b", c, bus.ram_we, exp_en); else pass_cnt++;
      chk_cnt++;
      if (bus.mem_ready !== exp_rdy) $display("FAIL store_ready c%0d got %b exp %b", c, bus.mem_ready, exp_rdy); else pass_cnt++;
      if (exp_en) begin
        chk_cnt++;
        if (bus.ram_addr !== 32'h80 || bus.ram_wdata !== 32'h12345678)
          $display("FAIL store_bus c%0d got %h/%h exp 00000080/12345678", c, bus.ram_addr, bus.ram_wdata);
        else pass_cnt++;
      end
      if (exp_rdy) begin
        chk_cnt++;
        if (bus.mem_rdata !== 32'hDEADBEEF) $display("FAIL store_keeps_rdata got %h exp deadbeef", bus.mem_rdata); else pass_cnt++;
      end
      tick();
    end
    bus.mem_wdata = 32'h0;
  endtask

  task automatic test_simultaneous();
    logic        exp_mrdy, exp_irdy;
    logic [31:0] exp_addr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    use_model = 1'b1;
    for (int c = 0; c < 13; c++) begin
      bus.mem_rd_en = RR_EN ? (c <= 11) : (c <= 7);
      bus.if_req    = RR_EN ? (c <= 7) : (c <= 11);
      bus.mem_addr  = (c <= 3) ? 32'h100 : 32'h104;
      bus.if_addr   = 32'h4;
      #1;
      exp_mrdy = RR_EN ? ((c == 3) || (c == 11)) : ((c == 3) || (c == 7));
      exp_irdy = RR_EN ? (c == 7) : (c == 11);
      chk_cnt++;
      if (bus.mem_ready !== exp_mrdy) $display("FAIL sim_mem_ready c%0d got %b exp %b", c, bus.mem_ready, exp_mrdy); else pass_cnt++;
      chk_cnt++;
      if (bus.if_ready !== exp_irdy) $display("FAIL sim_if_ready c%0d got %b exp %b", c, bus.if_ready, exp_irdy); else pass_cnt++;
      if (c == 3) begin
        chk_cnt++;
        if (bus.mem_rdata !== (32'h100 ^ K)) $display("FAIL sim_mem_rdata got %h exp %h", bus.mem_rdata, 32'h100 ^ K); else pass_cnt++;
      end
      if (c == 5) begin
        exp_addr = RR_EN ? 32'h4 : 32'h104;
        chk_cnt++;
        if (bus.ram_addr !== exp_addr) $display("FAIL sim_second_grant got %h exp %h", bus.ram_addr, exp_addr); else pass_cnt++;
      end
      if (exp_irdy) begin
        chk_cnt++;
        if (bus.if_rdata !== (32'h4 ^ K)) $display("FAIL sim_if_rdata got %h exp %h", bus.if_rdata, 32'h4 ^ K); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_rdy, exp_en;
    logic [31:0] exp_data;
    use_model = 1'b1;
    for (int c = 0; c < 13; c++) begin
      bus.if_req  = (c <= 11);
      bus.if_addr = 32'(c / 4 * 4);
      #1;
      exp_rdy = (c < 12) && (c % 4 == 3);
      exp_en  = (c < 12) && ((c % 4 == 1) || (c % 4 == 2));
      chk_cnt++;
      if (bus.if_ready !== exp_rdy) $display("FAIL b2b_if_ready c%0d got %b exp %b", c, bus.if_ready, exp_rdy); else pass_cnt++;
      chk_cnt++;
      if (bus.ram_en !== exp_en) $display("FAIL b2b_ram_en c%0d got %b exp %b", c, bus.ram_en, exp_en); else pass_cnt++;
      if (exp_rdy) begin
        exp_data = 32'(c / 4 * 4) ^ K;
        chk_cnt++;
        if (bus.if_rdata !== exp_data) $display("FAIL b2b_if_rdata c%0d got %h exp %h", c, bus.if_rdata, exp_data); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    logic exp_en, exp_rdy;
    use_model = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.mem_rd_en = (c <= 5);
      bus.mem_addr  = (c <= 1) ? 32'h40 : 32'h44;
      rst           = (c == 1);
      #1;
      exp_en  = (c == 1) || (c == 3) || (c == 4);
      exp_rdy = (c == 5);
      chk_cnt++;
      if (bus.ram_en !== exp_en) $display("FAIL rstmid_ram_en c%0d got %b exp %b", c, bus.ram_en, exp_en); else pass_cnt++;
      chk_cnt++;
      if (bus.mem_ready !== exp_rdy) $display("FAIL rstmid_ready c%0d got %b exp %b", c, bus.mem_ready, exp_rdy); else pass_cnt++;
      if (c == 2) begin
        chk_cnt++;
        if (bus.ram_addr !== 32'h0 || bus.mem_rdata !== 32'h0)
          $display("FAIL rstmid_cleared got %h/%h exp 0/0", bus.ram_addr, bus.mem_rdata);
        else pass_cnt++;
      end
      if (exp_rdy) begin
        chk_cnt++;
        if (bus.mem_rdata !== (32'h44 ^ K)) $display("FAIL rstmid_reissue got %h exp %h", bus.mem_rdata, 32'h44 ^ K); else pass_cnt++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_lat1();
    logic exp_en, exp_we, exp_rdy;
    for (int c = 0; c < 7; c++) begin
      bus1.mem_rd_en = (c <= 2);
      bus1.mem_wr_en = (c >= 3) && (c <= 5);
      bus1.mem_addr  = (c <= 2) ? 32'h20 : 32'h24;
      bus1.mem_wdata = 32'h55;
      #1;
      exp_en  = (c == 1) || (c == 4);
      exp_we  = (c == 4);
      exp_rdy = (c == 2) || (c == 5);
      chk_cnt++;
      if (bus1.ram_en !== exp_en) $display("FAIL lat1_ram_en c%0d got %b exp %b", c, bus1.ram_en, exp_en); else pass_cnt++;
      chk_cnt++;
      if (bus1.ram_we !== exp_we) $display("FAIL lat1_ram_we c%0d got %b exp %b", c, bus1.ram_we, exp_we); else pass_cnt++;
      chk_cnt++;
      if (bus1.mem_ready !== exp_rdy) $display("FAIL lat1_ready c%0d got %b exp %b", c, bus1.mem_ready, exp_rdy); else pass_cnt++;
      if (exp_rdy) begin
        chk_cnt++;
        if (bus1.mem_rdata !== (32'h20 ^ K) || bus1.pipe_freeze !== 1'b0)
          $display("FAIL lat1_rdata c%0d got %h/%b exp %h/0", c, bus1.mem_rdata, bus1.pipe_freeze, 32'h20 ^ K);
        else pass_cnt++;
      end
      if (exp_we) begin
        chk_cnt++;
        if (bus1.ram_addr !== 32'h24 || bus1.ram_wdata !== 32'h55)
          $display("FAIL lat1_store_bus got %h/%h exp 00000024/00000055", bus1.ram_addr, bus1.ram_wdata);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    use_model = 1'b0;
    ram_val   = 32'h0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_lat1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
